// File: rtl/decoder_proj.sv
// decoder_proj: registered multi-mode 4-bit decoder.
// io_in packs {mode[1:0], en, code[3:0]}. The decode result is one of
// one-hot, hex 7-segment, BCD 7-segment (codes 10-15 blank and flag err)
// or thermometer. It is registered once, so latency is one cycle.
// Optional feature macro: DECODER_PARITY_EN adds dec_par, the registered
// even parity of dec_out.
module decoder_proj (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  io_in,
    output logic [15:0] dec_out,
    output logic        valid,
    output logic        err
`ifdef DECODER_PARITY_EN
    ,
    output logic        dec_par
`endif
);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_HEX    = 2'b01,
        MODE_BCD    = 2'b10,
        MODE_THERM  = 2'b11
    } mode_t;

    // Segment pattern g..a (bit0 = a), active-high.
    function automatic logic [6:0] seg7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Returns {err, dec} for one code/mode pair.
    function automatic logic [16:0] decode(input mode_t mode, input logic [3:0] code);
        logic [15:0] d;
        logic        e;
        d = 16'h0000;
        e = 1'b0;
        case (mode)
            MODE_ONEHOT: d = 16'h0001 << code;
            MODE_HEX:    d = {9'h000, seg7(code)};
            MODE_BCD: begin
                if (code > 4'd9) begin
                    e = 1'b1;
                end else begin
                    d = {9'h000, seg7(code)};
                end
            end
            default:     d = (16'h0001 << code) - 16'h0001;
        endcase
        return {e, d};
    endfunction

    // ---- stage p0: unpack the bus and decode combinationally ----
    logic [3:0]  code_p0;
    logic        en_p0;
    mode_t       mode_p0;
    logic [15:0] dec_p0;
    logic        err_p0;

    assign code_p0 = io_in[3:0];
    assign en_p0   = io_in[4];
    assign mode_p0 = mode_t'(io_in[6:5]);

    // Combinational decode of the current bus value.
    always_comb begin
        {err_p0, dec_p0} = decode(mode_p0, code_p0);
    end

    // ---- stage p1: output register ----
    logic [15:0] dec_p1;
    logic        err_p1;
    logic        vld_p1;

    // Load the decode on enabled edges; hold data otherwise, valid pulses per sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_p1 <= 16'h0000;
            err_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= en_p0;
            if (en_p0) begin
                dec_p1 <= dec_p0;
                err_p1 <= err_p0;
            end
        end
    end

    assign dec_out = dec_p1;
    assign err     = err_p1;
    assign valid   = vld_p1;

`ifdef DECODER_PARITY_EN
    logic par_p1;

    // Parity is computed from the incoming decode so it stays aligned with dec_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_p1 <= 1'b0;
        end else if (en_p0) begin
            par_p1 <= ^dec_p0;
        end
    end

    assign dec_par = par_p1;
`endif

endmodule

// File: tb/tb_decoder_proj.sv
// Self-checking bench for decoder_proj: directed cases followed by random
// bus values, checked against a behavioural model of the decode rules.
module tb_decoder_proj;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  io_in;
    logic [15:0] dec_out;
    logic        valid;
    logic        err;
`ifdef DECODER_PARITY_EN
    logic        dec_par;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_out;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_par;

    logic [6:0] seg_table [16];

    decoder_proj dut (
        .clk     (clk),
        .rst     (rst),
        .io_in   (io_in),
        .dec_out (dec_out),
        .valid   (valid),
        .err     (err)
`ifdef DECODER_PARITY_EN
        ,
        .dec_par (dec_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: arithmetic form of each output format.
    task automatic model_sample(input logic [6:0] v);
        int code;
        int mode;
        code = int'(v[3:0]);
        mode = int'(v[6:5]);
        if (v[4]) begin
            exp_err = 1'b0;
            if (mode == 0) begin
                exp_out = 16'(2 ** code);
            end else if (mode == 1) begin
                exp_out = {9'h000, seg_table[code]};
            end else if (mode == 2) begin
                if (code >= 10) begin
                    exp_out = 16'h0000;
                    exp_err = 1'b1;
                end else begin
                    exp_out = {9'h000, seg_table[code]};
                end
            end else begin
                exp_out = 16'((2 ** code) - 1);
            end
            exp_par   = ^exp_out;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_out   = 16'h0000;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_par   = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dec_out"}, dec_out, exp_out);
        chk({tag, ".valid"}, {15'h0, valid}, {15'h0, exp_valid});
        chk({tag, ".err"}, {15'h0, err}, {15'h0, exp_err});
`ifdef DECODER_PARITY_EN
        chk({tag, ".dec_par"}, {15'h0, dec_par}, {15'h0, exp_par});
`endif
    endtask

    // Drive a bus value, let one edge sample it, then compare just after the edge.
    task automatic step(input logic [6:0] v, input string tag);
        io_in = v;
        @(posedge clk);
        #1;
        model_sample(v);
        chk_model(tag);
    endtask

    initial begin
        seg_table = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst   = 1'b0;
        io_in = 7'b1011110;
        model_reset();

        // Reset must act before the first clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async.dec_out", dec_out, 16'h0000);
        chk("reset_async.valid", {15'h0, valid}, 16'h0000);
        chk("reset_async.err", {15'h0, err}, 16'h0000);
`ifdef DECODER_PARITY_EN
        chk("reset_async.dec_par", {15'h0, dec_par}, 16'h0000);
`endif
        @(posedge clk);
        #1;
        chk("reset_held.dec_out", dec_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        step(7'b1011110, "bcd_illegal_14");
        chk("bcd14.const_out", dec_out, 16'h0000);
        chk("bcd14.const_err", {15'h0, err}, 16'h0001);
        chk("bcd14.const_valid", {15'h0, valid}, 16'h0001);

        step(7'b0011010, "onehot_10");
        chk("onehot10.const_out", dec_out, 16'h0400);
        chk("onehot10.const_err", {15'h0, err}, 16'h0000);

        step(7'b0001101, "hold_en0");
        chk("hold.const_out", dec_out, 16'h0400);
        chk("hold.const_valid", {15'h0, valid}, 16'h0000);

        step(7'b0111011, "hex_B");
        chk("hexB.const_out", dec_out, 16'h007C);

        step(7'b1010111, "bcd_7");
        chk("bcd7.const_out", dec_out, 16'h0007);
        chk("bcd7.const_err", {15'h0, err}, 16'h0000);

        step(7'b1111111, "therm_15");
        chk("therm15.const_out", dec_out, 16'h7FFF);

        step(7'b1110000, "therm_0");
        chk("therm0.const_out", dec_out, 16'h0000);
        chk("therm0.const_valid", {15'h0, valid}, 16'h0001);

        step(7'b1110011, "therm_3");
        chk("therm3.const_out", dec_out, 16'h0007);
`ifdef DECODER_PARITY_EN
        chk("therm3.const_par", {15'h0, dec_par}, 16'h0001);
        step(7'b0010101, "onehot_5_par");
        chk("onehot5.const_par", {15'h0, dec_par}, 16'h0001);
`endif

        // err must survive an en=0 cycle too.
        step(7'b1011100, "bcd_illegal_12");
        step(7'b0000001, "hold_err");
        chk("hold_err.const_err", {15'h0, err}, 16'h0001);

        // Random traffic, en set about three times in four.
        for (int i = 0; i < 60; i++) begin
            logic [6:0] v;
            v = 7'($urandom);
            v[4] = ($urandom_range(0, 3) != 0);
            step(v, $sformatf("rand%0d", i));
        end

        // Reset mid-operation while clk is high clears outputs at once.
        step(7'b0111000, "pre_reset_hex8");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        step(7'b0010011, "post_reset_onehot3");
        chk("post_reset.const_out", dec_out, 16'h0008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
